// File: rtl/result_checker.sv
// Hardware scoreboard: compares one Result per retired instruction against a table of expected values.
// Latency 1 cycle (outputs update on the edge ending the sample cycle); no backpressure, samples are never stalled.
module result_checker #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int SKIP  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          exp_we,
    input  logic [AW-1:0] exp_addr,
    input  logic [31:0]   exp_data,
    input  logic [AW:0]   num_checks,
    input  logic          start,
    input  logic          sample_en,
    input  logic [31:0]   result,
    output logic          busy,
    output logic          done,
    output logic          mismatch,
    output logic [AW:0]   pass_count,
    output logic [AW:0]   fail_count,
    output logic [AW-1:0] first_fail,
    output logic          any_fail
);

    localparam int SW = (SKIP > 1) ? $clog2(SKIP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CHECK, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     tbl_mem [DEPTH];
    logic [AW-1:0]   idx;
    logic [AW:0]     n_q;
    logic [AW:0]     n_clamped;
    logic [SW-1:0]   skip_cnt;
    logic            start_ok;
    logic            compare;
    logic            hit;
    logic            last;
    logic            skip_last;

    assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
    assign n_clamped = (num_checks > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_checks;
    assign compare   = (state_q == S_CHECK) && sample_en;
    assign hit       = (result == tbl_mem[idx]);
    assign last      = ({1'b0, idx} == n_q - (AW+1)'(1));
    assign skip_last = (skip_cnt == SW'(SKIP - 1));

    // Writes are dropped while a run is active so a run always sees a stable table.
    always_ff @(posedge clk) begin
        if (exp_we && !busy)
            tbl_mem[exp_addr] <= exp_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (n_clamped == '0)
                        state_d = S_DONE;
                    else if (SKIP > 0)
                        state_d = S_SKIP;
                    else
                        state_d = S_CHECK;
                end
            end
            S_SKIP:  if (sample_en && skip_last) state_d = S_CHECK;
            S_CHECK: if (sample_en && last)      state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_SKIP, S_CHECK: busy = 1'b1;
            S_DONE:          done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q        <= '0;
            idx        <= '0;
            skip_cnt   <= '0;
            pass_count <= '0;
            fail_count <= '0;
            first_fail <= '0;
            any_fail   <= 1'b0;
            mismatch   <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if (start_ok) begin
                n_q        <= n_clamped;
                idx        <= '0;
                skip_cnt   <= '0;
                pass_count <= '0;
                fail_count <= '0;
                first_fail <= '0;
                any_fail   <= 1'b0;
            end else if (state_q == S_SKIP && sample_en) begin
                skip_cnt <= skip_cnt + SW'(1);
            end else if (compare) begin
                idx <= idx + AW'(1);
                if (hit) begin
                    pass_count <= pass_count + (AW+1)'(1);
                end else begin
                    fail_count <= fail_count + (AW+1)'(1);
                    mismatch   <= 1'b1;
                    if (!any_fail) begin
                        any_fail   <= 1'b1;
                        first_fail <= idx;
                    end
                end
            end
        end
    end

endmodule
